ctrl_msg_receiver: RTL
======================

Name: ctrl_msg_receiver

Overview:
Upstream stage of the per-core debug unit. Watches the incoming ring slot stream and recognises complete control messages addressed to this core (or broadcast). Queues each one as a {source, type} pair and presents it to the debug unit as a one-cycle ctrlValid/ctrlSrc/ctrlType strobe, gated by a ready input. Also keeps a sticky protocol-error flag and a saturating drop counter for the debug path.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
DROPW, 8, width of the saturating drop counter

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-high reset
whichCore  in  4  this core's ring address
ringIn  in  32  ring data word for the current slot
slotTypeIn  in  4  slot type for the current slot
sourceIn  in  4  originating core of the current slot
ctrlReady  in  1  consumer may take a message this cycle
ctrlValid  out  1  one-cycle strobe: ctrlSrc/ctrlType are valid
ctrlSrc  out  4  source core of the delivered message
ctrlType  out  4  control type of the delivered message (0 start, 1 stop, 2 kill)
pending  out  1  FIFO not empty
dropCount  out  DROPW  messages dropped because the FIFO was full; saturates
protoErr  out  1  sticky: a header arrived mid-message

Behaviour:
- Reset values (asynchronous, active-high; applied immediately): ctrlValid=0, ctrlSrc=0, ctrlType=0, pending=0, dropCount=0, protoErr=0, FIFO empty, FSM in IDLE.
- Slot decode:
  - Header when slotTypeIn==SLOT_MSG_HDR. Header fields: dest=ringIn[31:28], msgType=ringIn[27:24], cType=ringIn[23:20], len=ringIn[5:0].
  - Data word when slotTypeIn==SLOT_MSG_DATA.
  - Any other slot type is ignored and does not affect the FSM.
- Match: msgType==MSG_CTRL and (dest==whichCore or dest==DEST_BCAST).
- FSM states:
  - IDLE:
    - Header with len==0: if it matches, go to COMMIT this cycle (enqueue at the next edge); if not, stay in IDLE.
    - Header with len>0: load remaining=len; latch match, sourceIn and cType; go to BODY.
  - BODY:
    - Each data slot decrements remaining.
    - On the slot that takes remaining from 1 to 0: go to COMMIT if latched match, else IDLE.
    - A header arriving in BODY sets protoErr and abandons the current message (never enqueued). That header is then processed as if the FSM were in IDLE, in the same cycle.
  - COMMIT:
    - Single cycle; writes the latched {src, type} into the FIFO.
    - A header arriving in the same cycle is processed as in IDLE.
- Payload words are counted, never stored.
- Enqueue when the FIFO is full: the entry is discarded and dropCount increments, saturating at all-ones.
- Dequeue: when the FIFO is non-empty and ctrlReady=1, the head entry is popped. ctrlValid=1 in that cycle (combinational from head and ctrlReady), and ctrlSrc/ctrlType equal the head fields.
  - When ctrlValid=0, ctrlSrc/ctrlType hold the head entry, or 0 if the FIFO is empty.
  - At most one delivery per cycle.
- Simultaneous enqueue and dequeue on a full FIFO: the pop frees space, so the enqueue succeeds and nothing is dropped.
- Same-cycle bypass is not allowed: an entry enqueued at edge N is deliverable in cycle N at the earliest.
  - Minimum latency is therefore 1 cycle from COMMIT to ctrlValid, i.e. 2 cycles after the final slot of the message.
- Pointers are log2(DEPTH)+1 bits wide: full when the MSBs differ and the low bits are equal; wrap-around is natural.
- protoErr and dropCount clear only on reset.

Decomposition:
- Shared package ring_pkg holds: SLOT_MSG_HDR=4'd8, SLOT_MSG_DATA=4'd9, MSG_CTRL=4'd1, DEST_BCAST=4'hF, CTRL_START=0, CTRL_STOP=1, CTRL_KILL=2, and the header field bit positions.
- One sub-module, ctrl_fifo: synchronous FIFO of width 8 and depth DEPTH with push/pop/full/empty and the reset behaviour above.

Test Plan:
1. whichCore=3; header {dest=3, msgType=1, cType=0, len=0} from sourceIn=1; ctrlReady=1 -> two cycles later ctrlValid=1 for one cycle, ctrlSrc=1, ctrlType=0, pending returns to 0.
2. Header dest=3, cType=2, len=2 followed by two data slots -> exactly one strobe with ctrlType=2, and only after the second data slot. Repeat with dest=5 -> no strobe. Repeat with dest=F -> one strobe.
3. Header len=3, one data slot, then a new header {dest=3, cType=1, len=0} -> protoErr=1; exactly one strobe with ctrlType=1; the interrupted message is never delivered.
4. ctrlReady=0; six matching len-0 headers with DEPTH=4 -> pending=1, dropCount=2. Raise ctrlReady -> four strobes on consecutive cycles, in arrival order.
5. FIFO full, ctrlReady=1, and a matching message commits in the same cycle as a pop -> dropCount unchanged; total of five strobes delivered.
6. Assert reset asynchronously mid-BODY with two entries queued -> all outputs 0 immediately. After release, one data slot produces no strobe, and the next len-0 matching header is delivered normally.

Source files
------------

// File: rtl/ring_pkg.sv
// Ring slot encodings, control-message header layout and the control-queue
// entry type shared by the control-message receiver and its FIFO.
package ring_pkg;

   // Slot types carried alongside each ring word
   localparam logic [3:0] SLOT_MSG_HDR  = 4'd8;
   localparam logic [3:0] SLOT_MSG_DATA = 4'd9;

   // Message classes and addressing
   localparam logic [3:0] MSG_CTRL   = 4'd1;
   localparam logic [3:0] DEST_BCAST = 4'hF;

   // Control message types
   localparam logic [3:0] CTRL_START = 4'd0;
   localparam logic [3:0] CTRL_STOP  = 4'd1;
   localparam logic [3:0] CTRL_KILL  = 4'd2;

   // Header field positions
   localparam int HDR_DEST_MSB  = 31;
   localparam int HDR_DEST_LSB  = 28;
   localparam int HDR_MTYPE_MSB = 27;
   localparam int HDR_MTYPE_LSB = 24;
   localparam int HDR_CTYPE_MSB = 23;
   localparam int HDR_CTYPE_LSB = 20;
   localparam int HDR_LEN_MSB   = 5;
   localparam int HDR_LEN_LSB   = 0;
   localparam int LEN_W         = HDR_LEN_MSB - HDR_LEN_LSB + 1;

   // Receiver FSM states
   typedef enum logic [1:0] {
      RX_IDLE   = 2'd0,
      RX_BODY   = 2'd1,
      RX_COMMIT = 2'd2
   } rxState_e;

   // One queued control message
   typedef struct packed {
      logic [3:0] src;
      logic [3:0] cType;
   } ctrlEntry_t;

   function automatic logic [3:0] hdrDest(input logic [31:0] word);
      return word[HDR_DEST_MSB:HDR_DEST_LSB];
   endfunction

   function automatic logic [3:0] hdrMsgType(input logic [31:0] word);
      return word[HDR_MTYPE_MSB:HDR_MTYPE_LSB];
   endfunction

   function automatic logic [3:0] hdrCType(input logic [31:0] word);
      return word[HDR_CTYPE_MSB:HDR_CTYPE_LSB];
   endfunction

   function automatic logic [LEN_W-1:0] hdrLen(input logic [31:0] word);
      return word[HDR_LEN_MSB:HDR_LEN_LSB];
   endfunction

   // A header is for us when it is a control message sent to this core or broadcast
   function automatic logic isCtrlMatch(input logic [31:0] word, input logic [3:0] core);
      return (hdrMsgType(word) == MSG_CTRL) &&
             ((hdrDest(word) == core) || (hdrDest(word) == DEST_BCAST));
   endfunction

endpackage

// File: rtl/ctrl_fifo.sv
// Small synchronous FIFO for queued control messages. Pointers carry one
// extra wrap bit so full and empty are told apart without a counter. A push
// into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module ctrl_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] pushData,
   input  logic             pop,
   output logic [WIDTH-1:0] headData,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wrPtr;
   logic [AW:0]      rdPtr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             doPush;
   logic             doPop;

   // Status flags, accepted operations and the head word (zero when empty)
   always_comb begin
      empty    = (wrPtr == rdPtr);
      full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
      doPop    = pop && !empty;
      doPush   = push && (!full || doPop);
      headData = empty ? '0 : mem[rdPtr[AW-1:0]];
   end

   // Pointer advance; wrap-around falls out of the extra MSB
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
      end
   end

   // Storage write; contents are don't-care until a pointer covers them
   always_ff @(posedge clock) begin
      if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
   end

endmodule

// File: rtl/ctrl_msg_receiver.sv
// Watches the ring slot stream, recognises complete control messages for
// this core (or broadcast), queues their {source, type} and hands them to
// the debug unit one per cycle. Also tracks a sticky protocol-error flag
// and a saturating count of messages lost to a full queue.
module ctrl_msg_receiver
   import ring_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DROPW = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [3:0]       whichCore,
   input  logic [31:0]      ringIn,
   input  logic [3:0]       slotTypeIn,
   input  logic [3:0]       sourceIn,
   input  logic             ctrlReady,
   output logic             ctrlValid,
   output logic [3:0]       ctrlSrc,
   output logic [3:0]       ctrlType,
   output logic             pending,
   output logic [DROPW-1:0] dropCount,
   output logic             protoErr
);

   // Delivery handshake: a message is transferred in exactly the cycle where
   // the queue is non-empty and ctrlReady is high; ctrlValid is asserted only
   // in that cycle, so valid never rises without the consumer accepting it.

   rxState_e         state;
   logic [LEN_W-1:0] remaining;
   logic             latchMatch;
   logic [3:0]       latchSrc;
   logic [3:0]       latchType;

   logic             isHdr;
   logic             isData;
   logic             hdrMatch;
   logic [LEN_W-1:0] hdrLength;
   logic             fifoPush;
   logic             fifoPop;
   logic             fifoFull;
   logic             fifoEmpty;
   ctrlEntry_t       pushEntry;
   ctrlEntry_t       headEntry;

   // Slot decode and queue-side handshake
   always_comb begin
      isHdr     = (slotTypeIn == SLOT_MSG_HDR);
      isData    = (slotTypeIn == SLOT_MSG_DATA);
      hdrMatch  = isCtrlMatch(ringIn, whichCore);
      hdrLength = hdrLen(ringIn);
      fifoPush  = (state == RX_COMMIT);
      pushEntry = '{src: latchSrc, cType: latchType};
      fifoPop   = !fifoEmpty && ctrlReady;
      ctrlValid = fifoPop;
      ctrlSrc   = headEntry.src;
      ctrlType  = headEntry.cType;
      pending   = !fifoEmpty;
   end

   // Message framing FSM: a header is handled the same way in every state,
   // abandoning any message still in its body and flagging the overlap
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= RX_IDLE;
         remaining  <= '0;
         latchMatch <= 1'b0;
         latchSrc   <= '0;
         latchType  <= '0;
         protoErr   <= 1'b0;
      end else if (isHdr) begin
         if (state == RX_BODY) protoErr <= 1'b1;
         remaining  <= hdrLength;
         latchMatch <= hdrMatch;
         latchSrc   <= sourceIn;
         latchType  <= hdrCType(ringIn);
         if (hdrLength != '0)  state <= RX_BODY;
         else if (hdrMatch)    state <= RX_COMMIT;
         else                  state <= RX_IDLE;
      end else begin
         case (state)
            RX_BODY: begin
               if (isData) begin
                  remaining <= remaining - 1'b1;
                  if (remaining == LEN_W'(1)) state <= latchMatch ? RX_COMMIT : RX_IDLE;
               end
            end
            RX_COMMIT: state <= RX_IDLE;
            default:   state <= RX_IDLE;
         endcase
      end
   end

   // Count commits lost to a full queue that no same-cycle pop rescues
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dropCount <= '0;
      end else if (fifoPush && fifoFull && !fifoPop && (dropCount != '1)) begin
         dropCount <= dropCount + 1'b1;
      end
   end

   ctrl_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(ctrlEntry_t))
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (fifoPush),
      .pushData (pushEntry),
      .pop      (fifoPop),
      .headData (headEntry),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

endmodule
